// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: access encodings, FSM states,
// default bus timeout and store-lane helpers.
package mem_stage_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // mem_op encodings; stores reuse the low two bits (00 byte, 01 half, 10 word)
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Sub-word store data is replicated so the bus picks it up on any lane
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the load type.
module load_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  mem_op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (mem_op_i)
      MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data_o = {24'h0, byte_sel};
      MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data_o = {16'h0, half_sel};
      MEM_W:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-bus accesses, waits for grant/read data with a
// timeout, aligns load data and registers the MEM/WB results.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_i,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic        mem_2_reg_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] alu_data_i,
  input  logic [4:0]  rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        mem_stall_o,
  output logic        misalign_exc_o,
  output logic        bus_err_o,
  output logic [1:0]  state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Handshake: dmem_req_o is held with addr/we/wdata/be frozen until a cycle in
  // which dmem_gnt_i is high; dmem_rvalid_i is only meaningful in ST_WAIT.

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dmem_req_q, dmem_we_q;
  logic [31:0]       dmem_addr_q, dmem_wdata_q;
  logic [3:0]        dmem_be_q;
  logic              wb_reg_write_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;
  logic              misalign_exc_q, bus_err_q;

  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic              is_store_q, mem_2_reg_q, reg_write_q, err_q;
  logic [4:0]        rd_q;
  logic [31:0]       alu_q, ldata_q;
  logic [31:0]       load_data;
  logic              mem_access;

  assign mem_access = mem_read_i | mem_write_i;

  load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .addr_i   (off_q),
    .mem_op_i (op_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_be_q      <= '0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misalign_exc_q <= 1'b0;
      bus_err_q      <= 1'b0;
      op_q           <= '0;
      off_q          <= '0;
      is_store_q     <= 1'b0;
      mem_2_reg_q    <= 1'b0;
      reg_write_q    <= 1'b0;
      err_q          <= 1'b0;
      rd_q           <= '0;
      alu_q          <= '0;
      ldata_q        <= '0;
    end else begin
      misalign_exc_q <= 1'b0;
      bus_err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!mem_access) begin
            wb_reg_write_q <= reg_write_i && (rd_i != 5'd0);
            wb_rd_q        <= rd_i;
            wb_data_q      <= alu_data_i;
          end else if (is_misaligned(mem_op_i[1:0], alu_data_i[1:0])) begin
            misalign_exc_q <= 1'b1;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= rd_i;
            wb_data_q      <= alu_data_i;
          end else begin
            state_q        <= ST_REQ;
            cnt_q          <= '0;
            dmem_req_q     <= 1'b1;
            dmem_we_q      <= mem_write_i;
            dmem_addr_q    <= {alu_data_i[31:2], 2'b00};
            dmem_be_q      <= mem_write_i ? store_be(mem_op_i[1:0], alu_data_i[1:0]) : 4'b1111;
            dmem_wdata_q   <= mem_write_i ? store_wdata(mem_op_i[1:0], rs2_data_i) : 32'h0;
            wb_reg_write_q <= 1'b0;
            op_q           <= mem_op_i;
            off_q          <= alu_data_i[1:0];
            is_store_q     <= mem_write_i;
            mem_2_reg_q    <= mem_2_reg_i;
            reg_write_q    <= reg_write_i;
            rd_q           <= rd_i;
            alu_q          <= alu_data_i;
            err_q          <= 1'b0;
          end
        end
        ST_REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;
            state_q    <= is_store_q ? ST_DONE : ST_WAIT;
          end else if (cnt_q >= CNT_LAST) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            bus_err_q  <= 1'b1;
            err_q      <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid_i) begin
            ldata_q <= load_data;
            state_q <= ST_DONE;
          end else if (cnt_q >= CNT_LAST) begin
            bus_err_q <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          wb_reg_write_q <= reg_write_q && !is_store_q && !err_q && (rd_q != 5'd0);
          wb_rd_q        <= rd_q;
          wb_data_q      <= mem_2_reg_q ? ldata_q : alu_q;
          err_q          <= 1'b0;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_stall_o    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign dmem_req_o     = dmem_req_q;
  assign dmem_we_o      = dmem_we_q;
  assign dmem_addr_o    = dmem_addr_q;
  assign dmem_wdata_o   = dmem_wdata_q;
  assign dmem_be_o      = dmem_be_q;
  assign wb_reg_write_o = wb_reg_write_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign misalign_exc_o = misalign_exc_q;
  assign bus_err_o      = bus_err_q;
  assign state_o        = state_q;

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the bus-wait cycles before a bus error.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 reg_write, mem_write, mem_read, mem_2_reg  in  1 each  controls from the EX/MEM register.
REQ-005 mem_op  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-006 rs2_data  in  32  store data; alu_data  in  32  address or ALU result; rd  in  5  destination register.
REQ-007 dmem_req, dmem_we  out  1  bus request and write strobe; dmem_addr  out  32; dmem_wdata  out  32; dmem_be  out  4  byte enables.
REQ-008 dmem_gnt  in  1  request accepted; dmem_rvalid  in  1  read data valid; dmem_rdata  in  32.
REQ-009 wb_reg_write  out  1; wb_rd  out  5; wb_data  out  32  registered MEM/WB results.
REQ-010 mem_stall  out  1  combinational freeze request to the hazard unit.
REQ-011 misalign_exc, bus_err  out  1  single-cycle registered pulses.

Function
REQ-012 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-013 IDLE, no memory op: mem_stall=0; wb_* SHALL load reg_write, rd, alu_data at the next edge, giving 1-cycle latency.
REQ-014 IDLE, mem_read or mem_write, aligned: the FSM SHALL go to REQ with mem_stall=1.
REQ-015 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no bus access and no stall.
REQ-016 On misalignment, misalign_exc=1 and wb_reg_write=0 SHALL apply for the next cycle.
REQ-017 REQ: dmem_req=1, dmem_addr={alu_data[31:2],2'b00}, and dmem_we=mem_write; these SHALL stay stable until dmem_gnt.
REQ-018 REQ exit on dmem_gnt: a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-019 WAIT: dmem_req=0; on dmem_rvalid the FSM SHALL capture dmem_rdata and go to DONE.
REQ-020 DONE: mem_stall=0; wb_* SHALL load at this edge; the FSM SHALL then go to IDLE.
REQ-021 mem_stall SHALL be 1 in every REQ and WAIT cycle.
REQ-022 Store lanes: SB SHALL set be=0001<<addr[1:0] and replicate rs2_data[7:0] on all four bytes.
REQ-023 SH SHALL set be=0011<<addr[1:0] and replicate rs2_data[15:0] on both halves; SW SHALL set be=1111.
REQ-024 Load extraction SHALL select the byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes 32 bits.
REQ-025 wb_data SHALL be the extracted load data when mem_2_reg=1, otherwise alu_data.
REQ-026 Stores and exceptions SHALL force wb_reg_write=0; rd=0 SHALL also force wb_reg_write=0.
REQ-027 A counter SHALL clear on entering REQ and increment in REQ/WAIT; at TIMEOUT_CYCLES, bus_err SHALL pulse, dmem_req drop, FSM go to DONE, and wb_reg_write=0.
REQ-028 dmem_gnt and dmem_rvalid in the same REQ cycle SHALL be treated as gnt only; rvalid SHALL be honoured only in WAIT.
REQ-029 dmem_rvalid in IDLE or DONE SHALL be ignored.

Reset
REQ-030 rst SHALL immediately force state to IDLE and clear the counter.
REQ-031 rst SHALL immediately force dmem_req, dmem_we, mem_stall, misalign_exc, bus_err, wb_reg_write, wb_rd, and wb_data to 0.
REQ-032 rst SHALL immediately force dmem_addr, dmem_wdata, and dmem_be to 0.
REQ-033 Reset mid-transaction SHALL abandon the access; a later dmem_rvalid SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the mem_op encodings, FSM state encodings, and the default TIMEOUT_CYCLES.
REQ-035 Byte/half extraction and extension SHALL live in sub-module load_align (inputs rdata, addr[1:0], mem_op; output data).

Verification
REQ-036 ALU op alu_data=0x1234, rd=5, reg_write=1 -> next cycle wb_data=0x1234, wb_rd=5, wb_reg_write=1, mem_stall never 1.
REQ-037 LB at addr 0x103, gnt on the 1st REQ cycle, rvalid rdata=0x80FF_0000 two cycles later -> wb_data=0xFFFF_FF80, stall high 3 cycles.
REQ-038 SH at addr 0x202, rs2_data=0xABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x200, wb_reg_write=0.
REQ-039 LW at addr 0x101 -> no dmem_req, misalign_exc pulses 1 cycle, wb_reg_write=0.
REQ-040 LW with gnt never asserted, TIMEOUT_CYCLES=4 -> bus_err after 4 REQ cycles, FSM returns to IDLE.
REQ-041 rst asserted in WAIT, then rvalid -> dmem_req=0 and mem_stall=0 at once; the rvalid causes no writeback.
